// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer in front of the 16x16 data RAM.
// Issues one RAM access per request, captures registered read data, returns it over a response channel.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        ram_cs,
  output logic        ram_rw,
  output logic [3:0]  ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy,
  output logic [7:0]  rd_count,
  output logic [7:0]  wr_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t      state, state_n;
  logic        we_q;
  logic [3:0]  addr_q;
  logic [15:0] wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // RAM pins depend only on state and request registers, never on live request inputs.
  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    ram_cs    = 1'b0;
    ram_rw    = 1'b1;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_n = ACCESS;
      end
      ACCESS: begin
        ram_cs  = 1'b1;
        ram_rw  = ~we_q;
        state_n = we_q ? IDLE : CAPTURE;
      end
      CAPTURE: state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
          end
        end
        ACCESS: begin
          if (we_q) wr_count <= wr_count + 8'd1;
        end
        CAPTURE: begin
          rsp_rdata <= ram_rdata;
          rsp_valid <= 1'b1;
          rd_count  <= rd_count + 8'd1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
